// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: memory op codes and alignment rule shared by the MEM-stage data port.
package dmem_responder_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    function automatic logic misaligned(input mem_op_e op, input logic [1:0] a);
        return ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && a[0]) ||
               ((op == MEM_LW || op == MEM_SW) && a != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: byte-enable/write-data generation and load lane extraction with sign/zero extension.
module dmem_lane
    import dmem_responder_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    logic [31:0] sh;
    always_comb begin
        err_o   = misaligned(op_i, addr_lo_i);
        sh      = rword_i >> {addr_lo_i, 3'b000};
        be_o    = err_o              ? 4'b0000 :
                  op_i == MEM_SB     ? 4'b0001 << addr_lo_i :
                  op_i == MEM_SH     ? 4'b0011 << addr_lo_i :
                  op_i == MEM_SW     ? 4'b1111 : 4'b0000;
        wdata_o = op_i == MEM_SB ? {4{wdata_i[7:0]}} :
                  op_i == MEM_SH ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = err_o           ? 32'h0 :
                  op_i == MEM_LB  ? {{24{sh[7]}}, sh[7:0]} :
                  op_i == MEM_LBU ? {24'h0, sh[7:0]} :
                  op_i == MEM_LH  ? {{16{sh[15]}}, sh[15:0]} :
                  op_i == MEM_LHU ? {16'h0, sh[15:0]} :
                  op_i == MEM_LW  ? rword_i : 32'h0;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave with req/ack handshake, wait states and stall request.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [3:0]            op_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  stallreq_o
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW+1:0]   addr_q, addr_c;
    logic [31:0]     data_q, data_c;
    mem_op_e         op_q, op_c;
    logic            we_q, we_c;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            idle, access;
    logic [3:0]      be;
    logic [31:0]     wdata, lane_rdata;
    logic            lane_err;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            unused_addr;

    assign unused_addr = ^addr_i[ADDR_WIDTH-1:IW+2];
    // With zero wait states the access happens in the sampling cycle, so use the live inputs.
    assign idle   = state_q == IDLE;
    assign addr_c = idle ? addr_i[IW+1:0] : addr_q;
    assign data_c = idle ? data_i : data_q;
    assign op_c   = idle ? mem_op_e'(op_i) : op_q;
    assign we_c   = idle ? we_i : we_q;

    dmem_lane u_lane (
        .op_i      (op_c),
        .addr_lo_i (addr_c[1:0]),
        .wdata_i   (data_c),
        .rword_i   (mem[addr_c[IW+1:2]]),
        .be_o      (be),
        .wdata_o   (wdata),
        .rdata_o   (lane_rdata),
        .err_o     (lane_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: if (req_i) begin
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                access  = (WAIT_CYCLES == 0);
            end
            WAIT: begin
                cnt_d = cnt_q - 4'(cnt_q != 4'd0);
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rdata_d = access ? lane_rdata : 32'h0;
        err_d   = access & lane_err;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            op_q    <= MEM_NONE;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (idle && req_i) begin
                addr_q <= addr_i[IW+1:0];
                data_q <= data_i;
                op_q   <= mem_op_e'(op_i);
                we_q   <= we_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (access && we_c && !rst_i)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_c[IW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign ack_o      = state_q == RESP;
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;
    assign stallreq_o = req_i & (state_q != RESP);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for a 2-wait-state and a 0-wait-state dmem_responder.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk, rst;
    logic        req_s, req_f, we;
    logic [31:0] addr, data;
    logic [3:0]  op;
    logic        ack_s, err_s, stall_s, ack_f, err_f, stall_f;
    logic [31:0] rdata_s, rdata_f;
    logic [32:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    dmem_responder #(.WAIT_CYCLES(2)) u_slow (
        .clk_i(clk), .rst_i(rst), .req_i(req_s), .we_i(we), .addr_i(addr), .data_i(data),
        .op_i(op), .ack_o(ack_s), .rdata_o(rdata_s), .err_o(err_s), .stallreq_o(stall_s)
    );

    dmem_responder #(.WAIT_CYCLES(0)) u_fast (
        .clk_i(clk), .rst_i(rst), .req_i(req_f), .we_i(we), .addr_i(addr), .data_i(data),
        .op_i(op), .ack_o(ack_f), .rdata_o(rdata_f), .err_o(err_f), .stallreq_o(stall_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic txn(input bit f, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] o, input logic [31:0] er, input bit ee, input string nm);
        int lat, stalls, wc;
        logic [32:0] exp;
        wc = f ? 0 : 2;
        sb.push_back({ee, er});
        we = w; addr = a; data = d; op = o;
        if (f) req_f = 1'b1; else req_s = 1'b1;
        lat = 0;
        stalls = 0;
        #1;
        while (!(f ? ack_f : ack_s) && lat < 20) begin
            if (f ? stall_f : stall_s) stalls++;
            @(negedge clk);
            lat++;
        end
        exp = sb.pop_front();
        checks++;
        if (lat != wc + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d, expected %0d", nm, lat, wc + 1);
        end
        checks++;
        if (stalls != wc + 1) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d, expected %0d", nm, stalls, wc + 1);
        end
        if (f ? ack_f : ack_s) begin
            checks++;
            if ((f ? stall_f : stall_s) !== 1'b0) begin
                errors++;
                $display("FAIL %s stall in ack cycle: got 1, expected 0", nm);
            end
            checks++;
            if ({(f ? err_f : err_s), (f ? rdata_f : rdata_s)} !== exp) begin
                errors++;
                $display("FAIL %s response: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                         nm, f ? err_f : err_s, f ? rdata_f : rdata_s, exp[32], exp[31:0]);
            end
        end
        req_s = 1'b0;
        req_f = 1'b0;
        @(negedge clk);
        checks++;
        if ((f ? ack_f : ack_s) !== 1'b0 || (f ? rdata_f : rdata_s) !== 32'h0 || (f ? err_f : err_s) !== 1'b0) begin
            errors++;
            $display("FAIL %s after ack: got ack=%0b rdata=%08h err=%0b, expected all 0",
                     nm, f ? ack_f : ack_s, f ? rdata_f : rdata_s, f ? err_f : err_s);
        end
    endtask

    task automatic test_reset();
        req_s = 0; req_f = 0; we = 0; addr = 0; data = 0; op = MEM_NONE;
        rst = 0;
        #2 rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack_s, err_s, stall_s, rdata_s, ack_f, err_f, stall_f, rdata_f} !== 70'h0) begin
            errors++;
            $display("FAIL reset outputs: got slow ack=%0b rdata=%08h err=%0b stall=%0b fast ack=%0b rdata=%08h, expected 0",
                     ack_s, rdata_s, err_s, stall_s, ack_f, rdata_f);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_word();
        txn(0, 1, 32'h10, 32'hDEADBEEF, MEM_SW, 32'h0, 0, "sw_10");
        txn(0, 0, 32'h10, 32'h0, MEM_LW, 32'hDEADBEEF, 0, "lw_10");
    endtask

    task automatic test_byte_half();
        txn(0, 1, 32'h13, 32'hABCDEF80, MEM_SB, 32'h0, 0, "sb_13");
        txn(0, 0, 32'h13, 32'h0, MEM_LB, 32'hFFFFFF80, 0, "lb_13");
        txn(0, 0, 32'h13, 32'h0, MEM_LBU, 32'h00000080, 0, "lbu_13");
        txn(0, 0, 32'h10, 32'h0, MEM_LW, 32'h80ADBEEF, 0, "lw_after_sb");
        txn(0, 0, 32'h12, 32'h0, MEM_LH, 32'hFFFF80AD, 0, "lh_12");
        txn(0, 0, 32'h10, 32'h0, MEM_LHU, 32'h0000BEEF, 0, "lhu_10");
    endtask

    task automatic test_misalign();
        txn(0, 1, 32'h11, 32'h1234, MEM_SH, 32'h0, 1, "sh_11_mis");
        txn(0, 0, 32'h10, 32'h0, MEM_LW, 32'h80ADBEEF, 0, "lw_after_bad_sh");
        txn(0, 0, 32'h22, 32'h0, MEM_LW, 32'h0, 1, "lw_22_mis");
        txn(0, 0, 32'h13, 32'h0, MEM_LHU, 32'h0, 1, "lhu_13_mis");
        txn(0, 0, 32'h10, 32'hFFFFFFFF, MEM_NONE, 32'h0, 0, "none_10");
        txn(0, 0, 32'h10, 32'h0, MEM_LW, 32'h80ADBEEF, 0, "lw_after_none");
    endtask

    task automatic test_alias();
        txn(0, 0, 32'h1010, 32'h0, MEM_LW, 32'h80ADBEEF, 0, "lw_alias");
        txn(0, 1, 32'h1011, 32'h00, MEM_SB, 32'h0, 0, "sb_alias");
        txn(0, 1, 32'h12, 32'hCAFE, MEM_SH, 32'h0, 0, "sh_12");
        txn(0, 0, 32'h10, 32'h0, MEM_LW, 32'hCAFE00EF, 0, "lw_after_alias");
    endtask

    task automatic test_reset_abort();
        txn(0, 1, 32'h20, 32'h11223344, MEM_SW, 32'h0, 0, "sw_20");
        we = 1; addr = 32'h20; data = 32'h55; op = MEM_SW; req_s = 1;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({ack_s, err_s, rdata_s} !== 34'h0) begin
            errors++;
            $display("FAIL reset in wait: got ack=%0b err=%0b rdata=%08h, expected 0", ack_s, err_s, rdata_s);
        end
        req_s = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst = 0;
            checks++;
            if (ack_s !== 1'b0) begin
                errors++;
                $display("FAIL abort no ack cycle %0d: got ack=%0b, expected 0", c, ack_s);
            end
        end
        txn(0, 0, 32'h20, 32'h0, MEM_LW, 32'h11223344, 0, "lw_20_after_abort");
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        txn(1, 1, 32'h0, 32'hA5A50001, MEM_SW, 32'h0, 0, "fast_sw_0");
        txn(1, 1, 32'h4, 32'h00000002, MEM_SW, 32'h0, 0, "fast_sw_4");
        sb.push_back({1'b0, 32'hA5A50001});
        we = 0; addr = 32'h0; op = MEM_LW; req_f = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (ack_f !== c[0] || stall_f !== !c[0]) begin
                errors++;
                $display("FAIL b2b cycle %0d: got ack=%0b stall=%0b, expected ack=%0b stall=%0b",
                         c, ack_f, stall_f, c[0], !c[0]);
            end
            if (ack_f) begin
                exp = sb.pop_front();
                checks++;
                if ({err_f, rdata_f} !== exp) begin
                    errors++;
                    $display("FAIL b2b data cycle %0d: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                             c, err_f, rdata_f, exp[32], exp[31:0]);
                end
                if (c < 5) begin
                    addr = (addr == 32'h0) ? 32'h4 : 32'h0;
                    sb.push_back({1'b0, (addr == 32'h0) ? 32'hA5A50001 : 32'h00000002});
                end else req_f = 0;
            end
        end
        @(negedge clk);
        checks++;
        if (ack_f !== 1'b0 || stall_f !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b end: got ack=%0b stall=%0b pending=%0d, expected 0 0 0", ack_f, stall_f, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_misalign();
        test_alias();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipeline's MEM stage. It accepts load/store requests through a req/ack handshake, inserts a configurable number of wait states, and performs byte, halfword or word access with sign/zero extension. While a request is outstanding it raises a stall request toward the pipeline controller. It is the slave end of the memory-access interface the MEM stage drives, and is the multi-cycle replacement for the single-cycle data port of the dual-port RAM.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width (fixed 32; byte lanes assume 4 bytes)
- DEPTH_WORDS, 1024, storage depth in words; power of two
- WAIT_CYCLES, 2, wait states inserted before access (0..15)
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  asynchronous reset, active-high
- req_i  input  1  request valid; held with all request fields stable until ack_o
- we_i  input  1  1 = store, 0 = load
- addr_i  input  ADDR_WIDTH  byte address
- data_i  input  DATA_WIDTH  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- op_i  input  4  memory op code (see Structure)
- ack_o  output  1  one-cycle completion pulse
- rdata_o  output  DATA_WIDTH  load result, valid while ack_o=1, else 0
- err_o  output  1  misaligned access flag, valid with ack_o
- stallreq_o  output  1  to pipe_ctrl: hold pipeline

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req_i=1, latch addr, data, op and we. Load the counter with WAIT_CYCLES. Go to WAIT, or directly to RESP when WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle. When the counter = 1 (or on entry with 0), perform the access and go to RESP.
- Access:
  - Word index = latched addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap.
  - Store writes only the selected byte lanes.
  - Load reads the word and selects the lane by addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - No write occurs, rdata_o=0, and err_o=1 with ack.
- MEM_NONE with req_i=1 completes as a no-op: ack, rdata 0, err 0.
- RESP: ack_o=1 and rdata_o/err_o are driven from registers. Always return to IDLE; a new request is sampled the next cycle.
- stallreq_o = req_i & (state≠RESP). It is combinational, so it drops in the ack cycle and the pipeline advances on that edge.
- Dropping req_i mid-transaction is a protocol violation. The latched transaction still completes and acks.
- Reset (asynchronous, any state): state=IDLE, counter=0, ack_o=0, rdata_o=0, err_o=0. An in-flight store is aborted with no write. Array contents are not reset.

## Timing
- Latency: req_i sampled high at edge N gives ack_o high during cycle N+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles after the request.
- The store takes effect at the edge entering RESP; a load issued next sees the new data.
- Throughput: one request per WAIT_CYCLES+2 cycles (RESP→IDLE costs one cycle).
- With WAIT_CYCLES=0: ack arrives the cycle after the request, and stallreq_o is high for exactly one cycle.

## Structure
- The MEM_* op codes go in defines.v, shared with exe and mem: MEM_NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
- The FSM state encodings are local to the module.
- One sub-module, dmem_lane: combinational byte-enable and write-data generation plus load extraction/extension from addr[1:0] and op.

## Test plan
- WAIT_CYCLES=2: SW 0xDEADBEEF to 0x10, then LW 0x10 → ack 3 cycles after each req, rdata_o=0xDEADBEEF, stallreq_o high for 3 cycles per request.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF.
- SH 0x1234 to 0x11 → err_o=1 with ack, and LW 0x10 is unchanged; LW at 0x22 → err_o=1, rdata_o=0.
- Address 0x1000+0x10 with DEPTH_WORDS=1024 → aliases word 4, so LW returns the prior 0x80ADBEEF.
- Assert rst_i during WAIT of SW 0x55 to 0x20 → outputs are 0 immediately, no ack, and a later LW 0x20 returns the old value.
- WAIT_CYCLES=0 back-to-back loads with req_i held high → ack every 2nd cycle, stallreq_o low in each ack cycle.
